// File: rtl/cache_pkg.sv
// Shared types and default dimensions for the direct-mapped cache access engine.
package cache_pkg;

  localparam int DEF_ADDR_W       = 15;
  localparam int DEF_INDEX_W      = 10;
  localparam int DEF_OFFSET_W     = 2;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ACCESS_LIMIT = 8192;
  localparam int DEF_CNT_W        = 14;

  localparam int TAG_W   = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
  localparam int BLOCK_W = DEF_DATA_W << DEF_OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    RESP   = 2'd3
  } cache_state_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BLOCK_W-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache: asynchronous read by index,
// synchronous block write on refill, valid bits cleared asynchronously by reset.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int IDX_W   = DEF_INDEX_W,
  parameter int LTAG_W  = TAG_W,
  parameter int LBLK_W  = BLOCK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_rd_index,
  output logic              o_rd_valid,
  output logic [LTAG_W-1:0] o_rd_tag,
  output logic [LBLK_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_index,
  input  logic [LTAG_W-1:0] i_wr_tag,
  input  logic [LBLK_W-1:0] i_wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  r_valid;
  logic [LTAG_W-1:0] r_tag  [LINES];
  logic [LBLK_W-1:0] r_data [LINES];

  // Valid bits: cleared on reset, set when a line is refilled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/cache_access_engine.sv
// Direct-mapped read-only cache with request/response handshake, block refill
// toward main memory and optional hit/access statistics.
// Optional feature macro: CACHE_STATS_EN (statistics counters and sticky access limit).
//
// state  | meaning
// IDLE   | ready for a request (unless the access limit was reached)
// LOOKUP | latched address compared against stored tag/valid
// REFILL | block fetch outstanding, mem_req held
// RESP   | one-cycle response pulse
module cache_access_engine
  import cache_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int INDEX_W      = DEF_INDEX_W,
  parameter int OFFSET_W     = DEF_OFFSET_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ACCESS_LIMIT = DEF_ACCESS_LIMIT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_hit,
  output logic                       mem_req,
  output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
  input  logic                       mem_rvalid,
  input  logic [(DATA_W<<OFFSET_W)-1:0] mem_rdata,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           access_count,
  output logic                       done
);

  localparam int LTAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LBLK_W = DATA_W << OFFSET_W;
  localparam int WPB    = 1 << OFFSET_W;

  // The counters must be able to represent the access limit itself
  if (ACCESS_LIMIT < 1 || ACCESS_LIMIT >= (1 << CNT_W)) begin : g_bad_limit
    $error("cache_access_engine: CNT_W too narrow for ACCESS_LIMIT");
  end

  cache_state_t              r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic                      r_req_ready;
  logic                      r_rsp_valid;
  logic [DATA_W-1:0]         r_rsp_data;
  logic                      r_rsp_hit;
  logic                      r_mem_req;
  logic [ADDR_W-OFFSET_W-1:0] r_mem_addr;

  logic [OFFSET_W-1:0]       w_offset;
  logic [INDEX_W-1:0]        w_index;
  logic [LTAG_W-1:0]         w_tag;
  logic                      w_rd_valid;
  logic [LTAG_W-1:0]         w_rd_tag;
  logic [LBLK_W-1:0]         w_rd_data;
  logic                      w_hit;
  logic                      w_fill;
  logic [WPB-1:0][DATA_W-1:0] w_line_words;
  logic [WPB-1:0][DATA_W-1:0] w_mem_words;
  logic                      w_done_next;

  assign w_offset = r_addr[OFFSET_W-1:0];
  assign w_index  = r_addr[OFFSET_W +: INDEX_W];
  assign w_tag    = r_addr[ADDR_W-1 -: LTAG_W];

  assign w_hit  = w_rd_valid && (w_rd_tag == w_tag);
  assign w_fill = (r_state == REFILL) && mem_rvalid;

  assign w_line_words = w_rd_data;
  assign w_mem_words  = mem_rdata;

  cache_line_store #(
    .IDX_W  (INDEX_W),
    .LTAG_W (LTAG_W),
    .LBLK_W (LBLK_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_index (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill),
    .i_wr_index (w_index),
    .i_wr_tag   (w_tag),
    .i_wr_data  (mem_rdata)
  );

  // Main lookup/refill/response sequencer with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_hit   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_addr      <= req_addr;
            r_req_ready <= 1'b0;
            r_state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= 1'b1;
            r_rsp_data  <= w_line_words[w_offset];
            r_state     <= RESP;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_addr[ADDR_W-1:OFFSET_W];
            r_state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            r_mem_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= 1'b0;
            r_rsp_data  <= w_mem_words[w_offset];
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_req_ready <= !w_done_next;
          r_state     <= IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_mem_req   <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_access_count;
  logic             r_done;
  logic             w_last_access;

  assign w_last_access = r_rsp_valid && !r_done &&
                         (r_access_count == CNT_W'(ACCESS_LIMIT - 1));
  assign w_done_next   = r_done || w_last_access;

  // Count each response until the access limit, then freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count    <= '0;
      r_access_count <= '0;
      r_done         <= 1'b0;
    end else if (r_rsp_valid && !r_done) begin
      r_access_count <= r_access_count + 1'b1;
      if (r_rsp_hit) begin
        r_hit_count <= r_hit_count + 1'b1;
      end
      if (w_last_access) begin
        r_done <= 1'b1;
      end
    end
  end

  assign hit_count    = r_hit_count;
  assign access_count = r_access_count;
  assign done         = r_done;
`else
  assign w_done_next  = 1'b0;
  assign hit_count    = '0;
  assign access_count = '0;
  assign done         = 1'b0;
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_hit   = r_rsp_hit;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_cache_access_engine.sv
// Directed plus randomized bench for cache_access_engine with a word-level
// reference model of the cache contents, memory contents and statistics.
module tb_cache_access_engine;

  localparam int ADDR_W       = 15;
  localparam int INDEX_W      = 10;
  localparam int OFFSET_W     = 2;
  localparam int DATA_W       = 32;
  localparam int ACCESS_LIMIT = 8192;
  localparam int CNT_W        = 14;
  localparam int BLOCK_W      = DATA_W << OFFSET_W;
  localparam int LINES        = 1 << INDEX_W;
  localparam int WPB          = 1 << OFFSET_W;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       req_valid = 1'b0;
  logic                       req_ready;
  logic [ADDR_W-1:0]          req_addr = '0;
  logic                       rsp_valid;
  logic [DATA_W-1:0]          rsp_data;
  logic                       rsp_hit;
  logic                       mem_req;
  logic [ADDR_W-OFFSET_W-1:0] mem_addr;
  logic                       mem_rvalid = 1'b0;
  logic [BLOCK_W-1:0]         mem_rdata = '0;
  logic [CNT_W-1:0]           hit_count;
  logic [CNT_W-1:0]           access_count;
  logic                       done;

  int checks   = 0;
  int failures = 0;

  bit ref_valid [LINES];
  int ref_tag   [LINES];
  int ref_acc;
  int ref_hits;
  bit ref_done;
  int fetches;
  logic [31:0] salt;

  always #5 clk = ~clk;

  cache_access_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_hit      (rsp_hit),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .hit_count    (hit_count),
    .access_count (access_count),
    .done         (done)
  );

  function automatic logic [DATA_W-1:0] mem_word(int a);
    return salt ^ (32'(a) * 32'h9E3779B1) ^ 32'h00A5_0000;
  endfunction

  function automatic logic [BLOCK_W-1:0] mem_block(int b);
    logic [BLOCK_W-1:0] blk;
    for (int w = 0; w < WPB; w++) blk[w*DATA_W +: DATA_W] = mem_word(b * WPB + w);
    return blk;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 0;
    end
    ref_acc  = 0;
    ref_hits = 0;
    ref_done = 1'b0;
  endtask

  task automatic chk_stats();
    chk("access_count", 32'(access_count), STATS ? ref_acc : 0);
    chk("hit_count", 32'(hit_count), STATS ? ref_hits : 0);
    chk("done", 32'(done), 32'(ref_done));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_hit", 32'(rsp_hit), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    model_clear();
    chk_stats();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full request/response transaction; the memory side answers after lat cycles.
  task automatic access(input int addr, input int lat);
    int idx;
    int tg;
    bit exp_hit;
    idx = (addr >> OFFSET_W) % LINES;
    tg  = addr >> (OFFSET_W + INDEX_W);
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    chk("pre_req_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_addr  = ADDR_W'(addr);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ADDR_W'($urandom);
    chk("lookup_rsp_valid", 32'(rsp_valid), 0);
    chk("lookup_mem_req", 32'(mem_req), 0);
    @(negedge clk);
    if (exp_hit) begin
      chk("hit_rsp_valid", 32'(rsp_valid), 1);
      chk("hit_rsp_hit", 32'(rsp_hit), 1);
      chk("hit_rsp_data", rsp_data, mem_word(addr));
      chk("hit_mem_req", 32'(mem_req), 0);
    end else begin
      chk("miss_mem_req", 32'(mem_req), 1);
      chk("miss_mem_addr", 32'(mem_addr), addr >> OFFSET_W);
      chk("miss_rsp_valid", 32'(rsp_valid), 0);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        chk("wait_mem_req", 32'(mem_req), 1);
        chk("wait_mem_addr", 32'(mem_addr), addr >> OFFSET_W);
        chk("wait_rsp_valid", 32'(rsp_valid), 0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = mem_block(addr >> OFFSET_W);
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      fetches++;
      chk("miss_rsp_valid_pulse", 32'(rsp_valid), 1);
      chk("miss_rsp_hit", 32'(rsp_hit), 0);
      chk("miss_rsp_data", rsp_data, mem_word(addr));
      chk("miss_mem_req_drop", 32'(mem_req), 0);
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
    end
    if (STATS && !ref_done) begin
      ref_acc++;
      if (exp_hit) ref_hits++;
      if (ref_acc == ACCESS_LIMIT) ref_done = 1'b1;
    end
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_req_ready", 32'(req_ready), 32'(!ref_done));
    chk_stats();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int a;
    salt = $urandom;
    fetches = 0;
    model_clear();

    // First access misses and returns word 1 of block 1
    do_reset();
    access(15'h0005, 3);

    // Re-access and neighbouring word hit without memory traffic
    f0 = fetches;
    access(15'h0005, 1);
    access(15'h0006, 1);
    chk("hits_no_fetch", 32'(fetches - f0), 0);

    // Same index, different tag: every access refills
    do_reset();
    f0 = fetches;
    access(15'h0005, 2);
    access(15'h1005, 0);
    access(15'h0005, 1);
    chk("conflict_fetches", 32'(fetches - f0), 3);

    // Reset in the middle of a refill
    do_reset();
    access(15'h0123, 0);
    req_valid = 1'b1;
    req_addr  = 15'h0123 + 15'h4000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_refill_mem_req", 32'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_refill_rst_mem_req", 32'(mem_req), 0);
    chk("mid_refill_rst_rsp_valid", 32'(rsp_valid), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = mem_block((15'h0123 + 15'h4000) >> OFFSET_W);
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("late_rvalid_rsp_valid", 32'(rsp_valid), 0);
      chk("late_rvalid_mem_req", 32'(mem_req), 0);
      chk("late_rvalid_ready", 32'(req_ready), 1);
      @(negedge clk);
    end
    access(15'h0123, 1);

    // Randomized traffic over a few indices to mix hits and conflicts
    for (int n = 0; n < 300; n++) begin
      int sel;
      int idx;
      sel = $urandom_range(0, 3);
      idx = (sel == 3) ? (LINES - 1) : sel;
      a = ($urandom_range(0, 2) << (OFFSET_W + INDEX_W)) | (idx << OFFSET_W) | $urandom_range(0, WPB - 1);
      access(a, $urandom_range(0, 4));
    end

`ifdef CACHE_STATS_EN
    // Sequential sweep up to the access limit
    do_reset();
    for (int i = 0; i < ACCESS_LIMIT; i++) access(i, $urandom_range(0, 1));
    chk("limit_done", 32'(done), 1);
    chk("limit_req_ready", 32'(req_ready), 0);
    chk("limit_access_count", 32'(access_count), ACCESS_LIMIT);
    chk("limit_hit_count", 32'(hit_count), 6144);
    req_valid = 1'b1;
    req_addr  = 15'h0005;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("frozen_rsp_valid", 32'(rsp_valid), 0);
      chk("frozen_mem_req", 32'(mem_req), 0);
      chk("frozen_req_ready", 32'(req_ready), 0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("frozen_access_count", 32'(access_count), ACCESS_LIMIT);
    chk("frozen_done", 32'(done), 1);
`else
    // Without statistics the engine never stops accepting
    do_reset();
    for (int i = 0; i < 10; i++) access(i, $urandom_range(0, 2));
    chk("nostats_access_count", 32'(access_count), 0);
    chk("nostats_hit_count", 32'(hit_count), 0);
    chk("nostats_done", 32'(done), 0);
    chk("nostats_req_ready", 32'(req_ready), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
